mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter for the CPU's single-port unified memory. It shares the memory between the fetch stage (read-only) and the memory stage (LDR/STR), and issues each access with the memory's fixed read latency. It returns read data with a one-cycle done pulse. It also drives `sel_stall` into the pipeline units while a requested access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 11, word-address width of the memory
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from address issue to valid `mem_rdata`; legal range ≥ 1
- `MAX_STARVE`, 4, consecutive lost arbitrations after which fetch is forced to win

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetch read request; level, held until `if_done`
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req`
- `if_done`  out  1  one-cycle pulse; `if_rdata` valid this cycle
- `if_rdata`  out  DATA_W  fetched instruction word
- `ls_req`  in  1  memory-stage request; level, held until `ls_done`
- `ls_we`  in  1  1 = STR (write), 0 = LDR (read)
- `ls_addr`  in  ADDR_W  load/store address
- `ls_wdata`  in  DATA_W  store data
- `ls_done`  out  1  one-cycle pulse; access complete, `ls_rdata` valid for reads
- `ls_rdata`  out  DATA_W  load data
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_w_en`  out  1  memory write enable
- `mem_rdata`  in  DATA_W  memory read data
- `sel_stall`  out  1  pipeline stall request
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: arbitrate the sampled requests.
  - ISSUE: drive `mem_addr`; pulse `mem_w_en` for writes.
  - WAIT: count `MEM_LAT` cycles for reads.
  - RESP: pulse the winner's done.
- Transitions:
  - IDLE→ISSUE when any req is high.
  - ISSUE→RESP for writes.
  - ISSUE→WAIT for reads.
  - WAIT→RESP when the latency counter reaches `MEM_LAT`.
  - RESP→IDLE always.
- Arbitration in IDLE:
  - `ls_req` wins over `if_req`.
  - Exception: fetch wins if the starve counter is ≥ `MAX_STARVE`.
  - The winner's ID, address, we and wdata are registered at grant.
- Starve counter:
  - Increments, saturating at `MAX_STARVE`, when `if_req` is high in IDLE and ls wins.
  - Clears on a fetch grant or when `if_req` is low in IDLE.
- `mem_addr` and `mem_wdata` are held from ISSUE through RESP. They are 0 in IDLE.
- In the last WAIT cycle, `mem_rdata` is captured into the winner's rdata register. The rdata registers hold their value until the next capture.
- `sel_stall` = (`ls_req` & ~`ls_done`) | (`if_req` & ~`if_done`). It is combinational from the inputs and registered done.
- Requester rules:
  - The requester must drop req in the cycle after done unless it is starting a new access.
  - Req high in the cycle after RESP is treated as a new request.
- If req drops mid-access (protocol violation), the access still completes and done still pulses.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, rdata registers 0.
- Reset asserted mid-access: the access is abandoned, no done pulse, and the FSM returns to IDLE next edge. A write already strobed stays committed in memory.
- Read latency: req seen in IDLE at cycle S; ISSUE at S+1; `mem_rdata` sampled at S+1+`MEM_LAT`; done at S+2+`MEM_LAT`.
  - `MEM_LAT`=2 gives done at S+4.
- Write latency: ISSUE at S+1 with `mem_w_en`=1 for exactly that cycle; done at S+2.
- Back-to-back accesses: minimum spacing between consecutive grants is 3 cycles for writes and `MEM_LAT`+3 for reads.
- Simultaneous reqs: one grant per IDLE cycle. The loser remains pending and is re-arbitrated at the next IDLE.
- Latency counter width is $clog2(`MEM_LAT`+1).

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum: IDLE, ISSUE, WAIT, RESP.
  - `req_id_t` enum: REQ_IF, REQ_LS.
- Sub-module `arb_starve_counter`: saturating counter with inputs `inc` and `clr`, output `starved`. Parameter: `MAX_STARVE`.
- Everything else (FSM, latency counter, capture registers) lives in the top module.

## Test plan
- Single LDR, `ls_addr`=0x010, memory returns 0xDEADBEEF at read latency 2 → `ls_done` 4 cycles after req seen, `ls_rdata`=0xDEADBEEF, `sel_stall` high until done.
- STR to 0x020 with `ls_wdata`=0x12345678 → `mem_w_en` high for exactly one cycle with `mem_addr`=0x020; `ls_done` 2 cycles after req.
- `if_req` and `ls_req` both raised in the same cycle → LS granted first; fetch `if_done` follows after the LS RESP; `if_rdata` matches memory at `if_addr`.
- `ls_req` held continuously with back-to-back reads while `if_req` stays high → fetch forced to win after 4 LS grants (`MAX_STARVE`=4); the starve counter then clears.
- `rst` pulsed during WAIT of a fetch read → no `if_done`; all outputs 0 next cycle; a new request after reset completes normally.
- Sweep `MEM_LAT`=1 and 3 → read done at S+3 and S+5 respectively; writes remain at S+2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of arbitrations fetch has lost in a row; 'starved' forces a fetch grant.
module arb_starve_counter #(
  parameter int MAX_STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  logic [CNT_W-1:0] cnt;

  // clr has priority so a fetch grant in the same cycle always restarts the count
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt < CNT_W'(MAX_STARVE))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign starved = (cnt >= CNT_W'(MAX_STARVE));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between fetch (read-only) and the memory stage,
// sequencing each access through IDLE/ISSUE/WAIT/RESP with the memory's fixed read latency.
//
// Handshake: a requester raises req (level) with stable address/data and holds it until
// its done pulses for one cycle; it must drop req the following cycle unless it is starting
// a new access. Req seen high in IDLE is a new request; a req dropped mid-access still
// completes and still gets its done pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel_stall,
  output logic              busy,
  output arb_state_t        state_dbg
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  arb_state_t        state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  req_id_t           win_id;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [DATA_W-1:0] win_wdata;
  logic              starved;
  logic              any_req;
  logic              grant_if;
  logic              lat_done;

  assign any_req  = if_req | ls_req;
  assign grant_if = if_req & (~ls_req | starved);
  assign lat_done = (state == WAIT) && (lat_cnt == LAT_W'(MEM_LAT));

  arb_starve_counter #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     ((state == IDLE) & if_req & ls_req & ~starved),
    .clr     ((state == IDLE) & (~if_req | grant_if)),
    .starved (starved)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = win_we ? RESP : WAIT;
      WAIT:    if (lat_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      win_id    <= REQ_IF;
      win_addr  <= '0;
      win_we    <= 1'b0;
      win_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && any_req) begin
        win_id    <= grant_if ? REQ_IF : REQ_LS;
        win_addr  <= grant_if ? if_addr : ls_addr;
        win_we    <= grant_if ? 1'b0 : ls_we;
        win_wdata <= grant_if ? '0 : ls_wdata;
      end
      // First WAIT cycle sees 1, so the last WAIT cycle lands MEM_LAT cycles after ISSUE
      if (state == ISSUE) begin
        lat_cnt <= LAT_W'(1);
      end else if ((state == WAIT) && !lat_done) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end else begin
        lat_cnt <= '0;
      end
      if (lat_done) begin
        if (win_id == REQ_IF) if_rdata <= mem_rdata;
        else                  ls_rdata <= mem_rdata;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_addr  = busy ? win_addr : '0;
  assign mem_wdata = busy ? win_wdata : '0;
  assign mem_w_en  = (state == ISSUE) && win_we;
  assign if_done   = (state == RESP) && (win_id == REQ_IF);
  assign ls_done   = (state == RESP) && (win_id == REQ_LS);
  assign sel_stall = (ls_req & ~ls_done) | (if_req & ~if_done);
  assign state_dbg = state;

endmodule
